// File: rtl/enemy_group.sv
// Multi-enemy movement and draw controller: per-slot position/direction/facing/alive state,
// Link-tracking move generation with random interrupts, and a sprite serialiser for the VGA writer.
module enemy_group #(
    parameter int          NUM_ENEMIES = 4,
    parameter int          SPRITE_W    = 16,
    parameter int          SPRITE_H    = 16,
    parameter int          STEP        = 1,
    parameter int          X_MAX       = 303,
    parameter int          Y_MAX       = 223,
    parameter int          SPAWN_X     = 210,
    parameter int          SPAWN_DX    = 20,
    parameter int          SPAWN_Y     = 96,
    parameter logic [5:0]  TRANSPARENT = 6'b111111
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic                                             init,
    input  logic                                             gen_move,
    input  logic                                             apply_move,
    input  logic                                             draw_start,
    input  logic [NUM_ENEMIES-1:0]                           collision,
    input  logic                                             kill_valid,
    input  logic [2:0]                                       kill_index,
    input  logic [8:0]                                       link_x_pos,
    input  logic [7:0]                                       link_y_pos,
    input  logic [4*NUM_ENEMIES-1:0]                         rand_bits,
    input  logic [5:0]                                       colour_in,
    output logic [9*NUM_ENEMIES-1:0]                         x_pos,
    output logic [8*NUM_ENEMIES-1:0]                         y_pos,
    output logic [3*NUM_ENEMIES-1:0]                         facing,
    output logic [NUM_ENEMIES-1:0]                           alive,
    output logic [1+$clog2(SPRITE_H)+$clog2(SPRITE_W):0]     sprite_addr,
    output logic [8:0]                                       x_draw,
    output logic [7:0]                                       y_draw,
    output logic [5:0]                                       colour,
    output logic                                             VGA_write,
    output logic                                             draw_done
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int CNT_W = COL_W + ROW_W;

    localparam logic [2:0] NO_ACTION = 3'b000;
    localparam logic [2:0] UP        = 3'b010;
    localparam logic [2:0] DOWN      = 3'b011;
    localparam logic [2:0] LEFT      = 3'b100;
    localparam logic [2:0] RIGHT     = 3'b101;

    localparam logic [9:0] STEP_V = 10'(STEP);
    localparam logic [9:0] XMAX_V = 10'(X_MAX);
    localparam logic [9:0] YMAX_V = 10'(Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PIXEL, S_FLUSH} draw_state_t;

    function automatic logic [8:0] spawn_x(input int i);
        int v;
        v = SPAWN_X + i * SPAWN_DX;
        if (v > X_MAX) v = X_MAX;
        return v[8:0];
    endfunction

    function automatic logic [1:0] bank_of(input logic [2:0] f);
        case (f)
            DOWN:    return 2'd0;
            LEFT:    return 2'd1;
            UP:      return 2'd2;
            RIGHT:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic [8:0]             x_q      [NUM_ENEMIES];
    logic [7:0]             y_q      [NUM_ENEMIES];
    logic [2:0]             dir_q    [NUM_ENEMIES];
    logic [2:0]             face_q   [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] alive_q;

    logic [2:0]             next_dir [NUM_ENEMIES];
    logic [8:0]             nx       [NUM_ENEMIES];
    logic [7:0]             ny       [NUM_ENEMIES];

    // Direction choice and clamped next position for every slot.
    always_comb begin
        logic [3:0] r;
        logic [9:0] xe;
        logic [9:0] ye;
        r  = 4'd0;
        xe = 10'd0;
        ye = 10'd0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            r = rand_bits[4*i +: 4];
            if (r[1:0] == 2'b11) begin
                case (r[3:2])
                    2'd0:    next_dir[i] = UP;
                    2'd1:    next_dir[i] = DOWN;
                    2'd2:    next_dir[i] = LEFT;
                    default: next_dir[i] = RIGHT;
                endcase
            end else if (link_y_pos < y_q[i]) begin
                next_dir[i] = UP;
            end else if (link_y_pos > y_q[i]) begin
                next_dir[i] = DOWN;
            end else if (link_x_pos < x_q[i]) begin
                next_dir[i] = LEFT;
            end else if (link_x_pos > x_q[i]) begin
                next_dir[i] = RIGHT;
            end else begin
                next_dir[i] = NO_ACTION;
            end

            xe = {1'b0, x_q[i]};
            ye = {2'b00, y_q[i]};
            case (dir_q[i])
                UP:      ye = (ye < STEP_V) ? 10'd0 : ye - STEP_V;
                DOWN:    ye = (ye + STEP_V > YMAX_V) ? YMAX_V : ye + STEP_V;
                LEFT:    xe = (xe < STEP_V) ? 10'd0 : xe - STEP_V;
                RIGHT:   xe = (xe + STEP_V > XMAX_V) ? XMAX_V : xe + STEP_V;
                default: ;
            endcase
            nx[i] = xe[8:0];
            ny[i] = ye[7:0];
        end
    end

    // Pulse priority is init > kill > gen_move > apply_move; only one acts per cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                x_q[i]     <= spawn_x(i);
                y_q[i]     <= 8'(SPAWN_Y);
                dir_q[i]   <= NO_ACTION;
                face_q[i]  <= DOWN;
                alive_q[i] <= 1'b1;
            end
        end else if (init) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                x_q[i]     <= spawn_x(i);
                y_q[i]     <= 8'(SPAWN_Y);
                dir_q[i]   <= NO_ACTION;
                face_q[i]  <= DOWN;
                alive_q[i] <= 1'b1;
            end
        end else if (kill_valid) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (kill_index == 3'(i)) alive_q[i] <= 1'b0;
            end
        end else if (gen_move) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (alive_q[i]) dir_q[i] <= next_dir[i];
            end
        end else if (apply_move) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (alive_q[i]) begin
                    if (dir_q[i] != NO_ACTION) face_q[i] <= dir_q[i];
                    if (!collision[i]) begin
                        x_q[i] <= nx[i];
                        y_q[i] <= ny[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_pack
        assign x_pos[9*g +: 9]  = x_q[g];
        assign y_pos[8*g +: 8]  = y_q[g];
        assign facing[3*g +: 3] = face_q[g];
    end
    assign alive = alive_q;

    draw_state_t      state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] count;
    logic [8:0]       base_x;
    logic [7:0]       base_y;
    logic [1:0]       bank_q;
    logic [8:0]       s1_x;
    logic [7:0]       s1_y;
    logic             s1_valid;

    logic             cur_live;
    logic [8:0]       cur_x;
    logic [7:0]       cur_y;
    logic [2:0]       cur_face;
    logic             last_slot;

    always_comb begin
        cur_live = 1'b0;
        cur_x    = 9'd0;
        cur_y    = 8'd0;
        cur_face = DOWN;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (idx == 4'(i)) begin
                cur_live = alive_q[i];
                cur_x    = x_q[i];
                cur_y    = y_q[i];
                cur_face = face_q[i];
            end
        end
    end

    assign last_slot = (idx == 4'(NUM_ENEMIES - 1));

    // Two-stage pixel path: address -> ROM data + stage-1 coordinates -> pixel outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= 4'd0;
            count       <= '0;
            base_x      <= 9'd0;
            base_y      <= 8'd0;
            bank_q      <= 2'd0;
            s1_x        <= 9'd0;
            s1_y        <= 8'd0;
            s1_valid    <= 1'b0;
            sprite_addr <= '0;
            x_draw      <= 9'd0;
            y_draw      <= 8'd0;
            colour      <= 6'd0;
            VGA_write   <= 1'b0;
            draw_done   <= 1'b0;
        end else begin
            draw_done <= 1'b0;
            s1_valid  <= 1'b0;
            VGA_write <= s1_valid && (colour_in != TRANSPARENT);
            if (s1_valid) begin
                x_draw <= s1_x;
                y_draw <= s1_y;
                colour <= colour_in;
            end

            if (init) begin
                state     <= S_IDLE;
                VGA_write <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (draw_start) begin
                            idx   <= 4'd0;
                            state <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (cur_live) begin
                            base_x      <= cur_x;
                            base_y      <= cur_y;
                            bank_q      <= bank_of(cur_face);
                            count       <= '0;
                            sprite_addr <= {bank_of(cur_face), {CNT_W{1'b0}}};
                            state       <= S_PIXEL;
                        end else if (last_slot) begin
                            state <= S_FLUSH;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    S_PIXEL: begin
                        s1_valid <= 1'b1;
                        s1_x     <= base_x + 9'(count[COL_W-1:0]);
                        s1_y     <= base_y + 8'(count[CNT_W-1:COL_W]);
                        if (&count) begin
                            if (last_slot) begin
                                state <= S_FLUSH;
                            end else begin
                                idx   <= idx + 4'd1;
                                state <= S_SCAN;
                            end
                        end else begin
                            count       <= count + 1'b1;
                            sprite_addr <= {bank_q, count + 1'b1};
                        end
                    end
                    S_FLUSH: begin
                        draw_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_group.sv
// Randomised scoreboard bench for enemy_group: a slot-level reference model predicts positions,
// facing, liveness and the full expected pixel stream of every draw.
module tb_enemy_group;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int H    = 16;
    localparam int XMAX = 303;
    localparam int YMAX = 223;
    localparam int STEP = 1;
    localparam int NA = 0, UP = 2, DN = 3, LF = 4, RT = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            init = 1'b0, gen_move = 1'b0, apply_move = 1'b0, draw_start = 1'b0;
    logic [N-1:0]    collision = '0;
    logic            kill_valid = 1'b0;
    logic [2:0]      kill_index = 3'd0;
    logic [8:0]      link_x_pos = 9'd0;
    logic [7:0]      link_y_pos = 8'd0;
    logic [4*N-1:0]  rand_bits = '0;
    logic [5:0]      colour_in = 6'd0;
    logic [9*N-1:0]  x_pos;
    logic [8*N-1:0]  y_pos;
    logic [3*N-1:0]  facing;
    logic [N-1:0]    alive;
    logic [9:0]      sprite_addr;
    logic [8:0]      x_draw;
    logic [7:0]      y_draw;
    logic [5:0]      colour;
    logic            VGA_write;
    logic            draw_done;

    enemy_group dut (
        .clock(clk), .reset(rst_n), .init(init), .gen_move(gen_move), .apply_move(apply_move),
        .draw_start(draw_start), .collision(collision), .kill_valid(kill_valid),
        .kill_index(kill_index), .link_x_pos(link_x_pos), .link_y_pos(link_y_pos),
        .rand_bits(rand_bits), .colour_in(colour_in), .x_pos(x_pos), .y_pos(y_pos),
        .facing(facing), .alive(alive), .sprite_addr(sprite_addr), .x_draw(x_draw),
        .y_draw(y_draw), .colour(colour), .VGA_write(VGA_write), .draw_done(draw_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    int mx[N], my[N], mdir[N], mface[N];
    bit malive[N];
    logic [22:0] exp_q[$];
    int n_checks = 0, n_pass = 0, n_writes = 0;
    int rom_mode = 0, rom_seed = 0;

    function automatic logic [5:0] rom_val(input int addr);
        int v;
        if (rom_mode == 0) return (addr == 5) ? 6'h3F : 6'h00;
        v = ((addr * 29) + rom_seed) & 63;
        return 6'(v);
    endfunction

    // Sprite ROM with one cycle of read latency
    always @(posedge clk) colour_in <= rom_val(int'(sprite_addr));

    function automatic int bank_of(input int f);
        case (f)
            LF:      return 1;
            UP:      return 2;
            RT:      return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_init();
        for (int i = 0; i < N; i++) begin
            mx[i] = (210 + 20 * i > XMAX) ? XMAX : 210 + 20 * i;
            my[i] = 96;
            mdir[i] = NA;
            mface[i] = DN;
            malive[i] = 1'b1;
        end
    endtask

    task automatic model_gen(input logic [4*N-1:0] rb, input int lx, input int ly);
        int r;
        int dtab[4] = '{UP, DN, LF, RT};
        for (int i = 0; i < N; i++) begin
            if (!malive[i]) continue;
            r = (rb >> (4 * i)) & 15;
            if ((r & 3) == 3)   mdir[i] = dtab[r >> 2];
            else if (ly < my[i]) mdir[i] = UP;
            else if (ly > my[i]) mdir[i] = DN;
            else if (lx < mx[i]) mdir[i] = LF;
            else if (lx > mx[i]) mdir[i] = RT;
            else                 mdir[i] = NA;
        end
    endtask

    task automatic model_apply(input logic [N-1:0] coll);
        for (int i = 0; i < N; i++) begin
            if (!malive[i]) continue;
            if (mdir[i] != NA) mface[i] = mdir[i];
            if (coll[i]) continue;
            case (mdir[i])
                UP: my[i] = (my[i] - STEP < 0) ? 0 : my[i] - STEP;
                DN: my[i] = (my[i] + STEP > YMAX) ? YMAX : my[i] + STEP;
                LF: mx[i] = (mx[i] - STEP < 0) ? 0 : mx[i] - STEP;
                RT: mx[i] = (mx[i] + STEP > XMAX) ? XMAX : mx[i] + STEP;
                default: ;
            endcase
        end
    endtask

    task automatic do_op(input bit i_init, input bit k, input int ki, input bit g, input bit a,
                         input logic [4*N-1:0] rb, input int lx, input int ly, input logic [N-1:0] coll);
        @(negedge clk);
        init = i_init; kill_valid = k; kill_index = 3'(ki); gen_move = g; apply_move = a;
        rand_bits = rb; link_x_pos = 9'(lx); link_y_pos = 8'(ly); collision = coll;
        if (i_init)     model_init();
        else if (k)     begin if (ki < N) malive[ki] = 1'b0; end
        else if (g)     model_gen(rb, lx, ly);
        else if (a)     model_apply(coll);
        @(negedge clk);
        init = 1'b0; kill_valid = 1'b0; gen_move = 1'b0; apply_move = 1'b0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s x%0d", tag, i), int'(x_pos[9*i +: 9]), mx[i]);
            check($sformatf("%s y%0d", tag, i), int'(y_pos[8*i +: 8]), my[i]);
            check($sformatf("%s facing%0d", tag, i), int'(facing[3*i +: 3]), mface[i]);
            check($sformatf("%s alive%0d", tag, i), int'(alive[i]), int'(malive[i]));
        end
    endtask

    task automatic build_expected(output int live, output int writes);
        int b;
        logic [5:0] c;
        live = 0;
        writes = 0;
        for (int s = 0; s < N; s++) begin
            if (!malive[s]) continue;
            live++;
            b = bank_of(mface[s]);
            for (int n = 0; n < W * H; n++) begin
                c = rom_val(b * W * H + n);
                if (c != 6'h3F) begin
                    exp_q.push_back({9'(mx[s] + n % W), 8'(my[s] + n / W), c});
                    writes++;
                end
            end
        end
    endtask

    task automatic run_draw(input string tag);
        int live, writes, cyc, extra;
        bit done;
        build_expected(live, writes);
        n_writes = 0;
        @(negedge clk);
        draw_start = 1'b1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < N + live * W * H + 40) begin
            @(negedge clk);
            cyc++;
            draw_start = 1'b0;
            if (draw_done) done = 1'b1;
        end
        draw_start = 1'b0;
        check({tag, " done_cycle"}, done ? cyc : -1, N + live * W * H + 2);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (draw_done) extra++;
        end
        check({tag, " done_once"}, extra, 0);
        check({tag, " writes"}, n_writes, writes);
        check({tag, " leftover"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every pixel write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && VGA_write) begin
            logic [22:0] e;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pixel unexpected: got x=%0d y=%0d c=%0d expected no write",
                         x_draw, y_draw, colour);
            end else begin
                e = exp_q.pop_front();
                check("pixel {x,y,c}", int'({x_draw, y_draw, colour}), int'(e));
            end
        end
    end

    initial begin
        int live_d, writes_d, dones;
        bit fi, fk, fg, fa;
        int lx, ly;

        // Reset state
        model_init();
        repeat (3) @(negedge clk);
        check("rst VGA_write", int'(VGA_write), 0);
        check("rst draw_done", int'(draw_done), 0);
        check("rst sprite_addr", int'(sprite_addr), 0);
        check("rst x_draw", int'(x_draw), 0);
        check("rst colour", int'(colour), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("reset");

        // Reset asserted in the middle of a draw
        rom_mode = 1; rom_seed = 11;
        build_expected(live_d, writes_d);
        @(negedge clk);
        draw_start = 1'b1;
        @(negedge clk);
        draw_start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset VGA_write", int'(VGA_write), 0);
        check("midreset draw_done", int'(draw_done), 0);
        exp_q.delete();
        model_init();
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (draw_done) dones++;
        end
        check("midreset no done", dones, 0);
        check_state("after midreset");
        check("slot0 x", int'(x_pos[8:0]), 210);
        check("slot3 x", int'(x_pos[35:27]), 270);
        check("alive mask", int'(alive), 15);

        // Tracking LEFT then random-interrupt DOWN
        do_op(0, 0, 0, 1, 0, 16'h0000, 100, 96, 4'b0000);
        do_op(0, 0, 0, 0, 1, 16'h0000, 100, 96, 4'b0000);
        check("slot0 x after LEFT", int'(x_pos[8:0]), 209);
        check("slot0 facing LEFT", int'(facing[2:0]), LF);
        check_state("track left");
        do_op(0, 0, 0, 1, 0, 16'h0007, 100, 96, 4'b0000);
        do_op(0, 0, 0, 0, 1, 16'h0007, 100, 96, 4'b0000);
        check("slot0 y after DOWN", int'(y_pos[7:0]), 97);
        check_state("rand down");

        // Right edge clamp, then collision gating
        do_op(1, 0, 0, 0, 0, '0, 0, 0, '0);
        do_op(0, 0, 0, 1, 0, 16'h0000, 511, 96, 4'b0000);
        repeat (80) do_op(0, 0, 0, 0, 1, 16'h0000, 511, 96, 4'b0000);
        check("slot1 x clamp", int'(x_pos[17:9]), 303);
        check_state("xmax clamp");
        do_op(0, 0, 0, 1, 0, 16'h0300, 511, 96, 4'b0000);
        do_op(0, 0, 0, 0, 1, 16'h0300, 511, 96, 4'b0100);
        check("slot2 y blocked", int'(y_pos[23:16]), 96);
        check("slot2 facing UP", int'(facing[8:6]), UP);
        check_state("collision");

        // Top edge and bottom edge clamps
        do_op(0, 0, 0, 1, 0, 16'h3333, 0, 0, 4'b0000);
        repeat (100) do_op(0, 0, 0, 0, 1, 16'h3333, 0, 0, 4'b0000);
        check("slot0 y top", int'(y_pos[7:0]), 0);
        check_state("ymin clamp");
        do_op(0, 0, 0, 1, 0, 16'h7777, 0, 0, 4'b0000);
        repeat (230) do_op(0, 0, 0, 0, 1, 16'h7777, 0, 0, 4'b0000);
        check("slot0 y bottom", int'(y_pos[7:0]), 223);
        check_state("ymax clamp");

        // Kill slot 1 and draw with a mostly-zero ROM
        do_op(1, 0, 0, 0, 0, '0, 0, 0, '0);
        do_op(0, 1, 1, 0, 0, '0, 0, 0, '0);
        check_state("kill1");
        rom_mode = 0;
        run_draw("draw3");

        // Out-of-range kill is ignored, then kill everything and draw
        do_op(0, 1, 6, 0, 0, '0, 0, 0, '0);
        check_state("kill6");
        do_op(0, 1, 0, 0, 0, '0, 0, 0, '0);
        do_op(0, 1, 2, 0, 0, '0, 0, 0, '0);
        do_op(0, 1, 3, 0, 0, '0, 0, 0, '0);
        check("all dead", int'(alive), 0);
        run_draw("draw0");

        // init wins over coincident kill and apply
        do_op(1, 1, 0, 0, 1, '0, 0, 0, '0);
        check("init prio alive", int'(alive), 15);
        check_state("init prio");

        // Randomised operations with periodic draws
        for (int it = 0; it < 150; it++) begin
            fi = ($urandom_range(0, 19) == 0);
            fk = ($urandom_range(0, 9) == 0);
            fg = 1'($urandom_range(0, 1));
            fa = 1'($urandom_range(0, 1));
            lx = $urandom_range(0, 400);
            ly = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) begin
                lx = mx[0];
                ly = my[0];
            end
            do_op(fi, fk, $urandom_range(0, 7), fg, fa, 16'($urandom), lx, ly, 4'($urandom));
            check_state($sformatf("rand%0d", it));
            if (it % 30 == 29) begin
                rom_mode = 1;
                rom_seed = $urandom_range(0, 63);
                run_draw($sformatf("rdraw%0d", it));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
